// File: rtl/mm_tile_scheduler_if.sv
// Tile-engine handshake and output-RAM write channel of the tile scheduler.
// The master is the scheduler; the slave is the tile engine plus output RAM.
interface mm_tile_scheduler_if #(
  parameter int Tn     = 4,
  parameter int ADDR_W = 8
);
  logic                        blk_start;
  logic [7:0]                  block_row;
  logic [7:0]                  block_col;
  logic [Tn-1:0][Tn-1:0][15:0] blk_result;
  logic                        blk_done;
  logic                        out_we;
  logic                        out_ready;
  logic [ADDR_W-1:0]           out_addr;
  logic [15:0]                 out_data;

  modport master (
    output blk_start, block_row, block_col, out_we, out_addr, out_data,
    input  blk_result, blk_done, out_ready
  );

  modport slave (
    input  blk_start, block_row, block_col, out_we, out_addr, out_data,
    output blk_result, blk_done, out_ready
  );
endinterface

// File: rtl/mm_tile_scheduler.sv
// Walks all Tn x Tn output tiles row-major, captures each tile result and drains it to RAM.
// Optional MM_TILE_SCHED_PERF_CNT_EN adds cycle_cnt / stall_cnt performance counters.
//
// state     | meaning
// S_IDLE    | waiting for start
// S_ISSUE   | one-cycle blk_start to the tile engine
// S_WAIT    | tile engine computing; blk_done sets pend
// S_CAPTURE | pend held until the drain engine is free, then copy result and advance
// S_FIN     | last tile captured; wait for its drain, then pulse done
module mm_tile_scheduler #(
  parameter int N      = 16,
  parameter int Tn     = 4,
  parameter int ADDR_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic done,
  mm_tile_scheduler_if.master bus
`ifdef MM_TILE_SCHED_PERF_CNT_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] stall_cnt
`endif
);

  localparam int IW = (Tn > 1) ? $clog2(Tn) : 1;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_CAPTURE, S_FIN} state_t;

  state_t                      state_q, state_d;
  logic                        pend_q;
  logic [7:0]                  row_q, col_q;
  logic [7:0]                  tile_row_q, tile_col_q;
  logic [Tn-1:0][Tn-1:0][15:0] buf_q;
  logic                        drain_q;
  logic [IW-1:0]               i_q, j_q;
  logic                        capture, last_tile, xfer;

  assign last_tile = (row_q == 8'(N - Tn)) && (col_q == 8'(N - Tn));
  assign xfer      = drain_q && bus.out_ready;

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE:    if (start) state_d = S_ISSUE;
      S_ISSUE:   state_d = S_WAIT;
      S_WAIT:    if (bus.blk_done) state_d = S_CAPTURE;
      S_CAPTURE: if (pend_q && !drain_q) begin
        capture = 1'b1;
        state_d = last_tile ? S_FIN : S_ISSUE;
      end
      S_FIN:     if (!drain_q) begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pend_q     <= 1'b0;
      row_q      <= '0;
      col_q      <= '0;
      tile_row_q <= '0;
      tile_col_q <= '0;
      buf_q      <= '0;
      drain_q    <= 1'b0;
      i_q        <= '0;
      j_q        <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && start) begin
        row_q <= '0;
        col_q <= '0;
      end
      if (state_q == S_WAIT && bus.blk_done) pend_q <= 1'b1;
      else if (capture)                      pend_q <= 1'b0;
      // Capture only happens with the drain idle, so it never collides with a transfer.
      if (capture) begin
        buf_q      <= bus.blk_result;
        tile_row_q <= row_q;
        tile_col_q <= col_q;
        if (col_q == 8'(N - Tn)) begin
          col_q <= '0;
          row_q <= last_tile ? 8'd0 : row_q + 8'(Tn);
        end else begin
          col_q <= col_q + 8'(Tn);
        end
        drain_q <= 1'b1;
        i_q     <= '0;
        j_q     <= '0;
      end else if (xfer) begin
        if (j_q == IW'(Tn - 1)) begin
          j_q <= '0;
          if (i_q == IW'(Tn - 1)) begin
            i_q     <= '0;
            drain_q <= 1'b0;
          end else begin
            i_q <= i_q + IW'(1);
          end
        end else begin
          j_q <= j_q + IW'(1);
        end
      end
    end
  end

  assign busy          = (state_q != S_IDLE);
  assign bus.blk_start = (state_q == S_ISSUE);
  assign bus.block_row = row_q;
  assign bus.block_col = col_q;
  assign bus.out_we    = drain_q;
  assign bus.out_addr  = drain_q ?
    ADDR_W'((int'(tile_row_q) + int'(i_q)) * N + int'(tile_col_q) + int'(j_q)) : '0;
  assign bus.out_data  = drain_q ? buf_q[i_q][j_q] : '0;

`ifdef MM_TILE_SCHED_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt <= '0;
      stall_cnt <= '0;
    end else if (state_q == S_IDLE && start) begin
      cycle_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (busy && cycle_cnt != 32'hFFFF_FFFF) cycle_cnt <= cycle_cnt + 32'd1;
      if (drain_q && !bus.out_ready && stall_cnt != 32'hFFFF_FFFF) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mm_tile_scheduler.sv
// Scoreboard bench for mm_tile_scheduler: tile model pushes expected writes, monitor pops them.
`timescale 1ns/1ps
module tb_mm_tile_scheduler;
  localparam int N  = 16;
  localparam int TN = 4;
  localparam int AW = 8;
  localparam int NT = (N / TN) * (N / TN);

  typedef struct packed {
    logic [7:0]  addr;
    logic [15:0] data;
  } exp_t;

  logic clk, rst, start, busy, done;
`ifdef MM_TILE_SCHED_PERF_CNT_EN
  logic [31:0] cycle_cnt, stall_cnt;
`endif

  mm_tile_scheduler_if #(.Tn(TN), .ADDR_W(AW)) bus ();

  mm_tile_scheduler #(.N(N), .Tn(TN), .ADDR_W(AW)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .busy  (busy),
    .done  (done),
    .bus   (bus)
`ifdef MM_TILE_SCHED_PERF_CNT_EN
    ,
    .cycle_cnt (cycle_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  int   vectors;
  int   miscompares;
  int   cyc;
  exp_t exp_q[$];
  int   model_lat;
  int   ready_mode;
  int   gap_mode;
  int   job_start_cyc;
  int   stray_req;
  int   xfers;
  int   done_seen;
  int   done_cyc;
  int   last_cyc;
  int   wcnt[256];
  logic [15:0] data_at[256];

  function automatic void check(string name, int act, int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, req, $time);
    end
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Tile engine model: result[i][j] = tile*16 + i*4 + j after model_lat cycles.
  initial begin
    int cnt, tile, exp_tile, stray_ack, r, c;
    cnt = 0; tile = 0; exp_tile = 0; stray_ack = 0;
    bus.blk_done   = 1'b0;
    bus.blk_result = '0;
    forever begin
      @(negedge clk);
      bus.blk_done = 1'b0;
      if (stray_req != stray_ack) begin
        stray_ack    = stray_req;
        bus.blk_done = 1'b1;
      end else if (rst || !busy) begin
        cnt      = 0;
        exp_tile = 0;
      end else if (bus.blk_start) begin
        check("origin_row", int'(bus.block_row), (exp_tile / 4) * TN);
        check("origin_col", int'(bus.block_col), (exp_tile % 4) * TN);
        if (exp_tile > 0) begin
          check("prev_drain_started", int'(bus.out_we), 1);
          check("prev_drain_addr", int'(bus.out_addr),
                ((exp_tile - 1) / 4) * TN * N + ((exp_tile - 1) % 4) * TN);
        end
        tile           = exp_tile;
        exp_tile       = exp_tile + 1;
        cnt            = model_lat;
        bus.blk_result = '0;
      end else if (cnt > 0) begin
        cnt = cnt - 1;
        if (cnt == 0) begin
          r = (tile / 4) * TN;
          c = (tile % 4) * TN;
          for (int i = 0; i < TN; i++) begin
            for (int j = 0; j < TN; j++) begin
              bus.blk_result[i][j] = 16'(tile * 16 + i * 4 + j);
              exp_q.push_back('{addr: 8'((r + i) * N + c + j), data: 16'(tile * 16 + i * 4 + j)});
            end
          end
          bus.blk_done = 1'b1;
        end
      end
    end
  end

  // out_ready driver and write monitor.
  initial begin
    int   ph, in_tile, tiles_drained;
    bit   pw, have_last, prev_busy;
    logic [7:0]  pa;
    logic [15:0] pd;
    exp_t e;
    ph = 0; in_tile = 0; tiles_drained = 0; pw = 0; have_last = 0; prev_busy = 0;
    pa = '0; pd = '0;
    bus.out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!busy) ph = 0;
      case (ready_mode)
        1: begin
          if (bus.out_we) begin
            bus.out_ready = (ph == 2);
            ph = (ph + 1) % 3;
          end else begin
            bus.out_ready = 1'b0;
          end
        end
        2:       bus.out_ready = (cyc - job_start_cyc > 41);
        default: bus.out_ready = 1'b1;
      endcase
      #1;
      if (rst) begin
        pw = 0; in_tile = 0; have_last = 0; prev_busy = 0;
        continue;
      end
      if (busy && !prev_busy) begin
        xfers = 0; done_seen = 0; in_tile = 0; tiles_drained = 0; have_last = 0;
        for (int a = 0; a < 256; a++) wcnt[a] = 0;
      end
      prev_busy = busy;
      if (pw) begin
        check("stall_hold_we", int'(bus.out_we), 1);
        check("stall_hold_addr", int'(bus.out_addr), int'(pa));
        check("stall_hold_data", int'(bus.out_data), int'(pd));
      end
      pw = bus.out_we && !bus.out_ready;
      pa = bus.out_addr;
      pd = bus.out_data;
      if (bus.out_we && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write_addr", int'(bus.out_addr), -1);
        end else begin
          e = exp_q.pop_front();
          check("write_addr", int'(bus.out_addr), int'(e.addr));
          check("write_data", int'(bus.out_data), int'(e.data));
        end
        wcnt[bus.out_addr]    = wcnt[bus.out_addr] + 1;
        data_at[bus.out_addr] = bus.out_data;
        if (in_tile == 0 && gap_mode != 0 && have_last)
          check("capture_gap", cyc - last_cyc, 2);
        in_tile = in_tile + 1;
        xfers   = xfers + 1;
        if (in_tile == TN * TN) begin
          in_tile   = 0;
          last_cyc  = cyc;
          have_last = 1;
          if (gap_mode != 0 && tiles_drained < NT - 1)
            check("blk_done_coincident", int'(bus.blk_done), 1);
          tiles_drained = tiles_drained + 1;
        end
      end
      if (done) begin
        done_seen = done_seen + 1;
        done_cyc  = cyc;
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    start         = 1'b1;
    job_start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    #2 check("busy_after_start", int'(busy), 1);
  endtask

  task automatic run_job(int lat, int mode, int gap, bit poke);
    int t, full;
    model_lat  = lat;
    ready_mode = mode;
    gap_mode   = gap;
    pulse_start();
    t = 0;
    while (done_seen == 0 && t < 20000) begin
      @(negedge clk);
      start = (poke && t == 100);
      #2;
      t++;
    end
    start = 1'b0;
    if (done_seen == 0) check("job_timeout", 0, 1);
    repeat (3) @(negedge clk);
    #2;
    check("done_count", done_seen, 1);
    check("done_after_last_xfer", done_cyc - last_cyc, 1);
    check("busy_low_after", int'(busy), 0);
    check("queue_empty", exp_q.size(), 0);
    check("xfer_count", xfers, N * N);
    full = 0;
    for (int a = 0; a < N * N; a++) if (wcnt[a] == 1) full++;
    check("addrs_written_once", full, N * N);
`ifdef MM_TILE_SCHED_PERF_CNT_EN
    check("cycle_cnt", int'(cycle_cnt), done_cyc - job_start_cyc);
`endif
  endtask

  initial begin
    int t;
    rst = 1'b1; start = 1'b0; model_lat = 20; ready_mode = 0; gap_mode = 0;
    stray_req = 0;
    repeat (3) @(negedge clk);
    #2;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_blk_start", int'(bus.blk_start), 0);
    check("rst_block_row", int'(bus.block_row), 0);
    check("rst_block_col", int'(bus.block_col), 0);
    check("rst_out_we", int'(bus.out_we), 0);
    check("rst_out_addr", int'(bus.out_addr), 0);
    check("rst_out_data", int'(bus.out_data), 0);
    @(negedge clk);
    rst = 1'b0;

    // Stray blk_done while idle.
    stray_req = stray_req + 1;
    repeat (4) @(negedge clk);
    #2;
    check("stray_busy", int'(busy), 0);
    check("stray_blk_start", int'(bus.blk_start), 0);
    check("stray_out_we", int'(bus.out_we), 0);

    run_job(20, 0, 0, 0);
    check("addr44_data", int'(data_at[8'h44]), 80);
    check("addr255_data", int'(data_at[8'hFF]), 255);

    run_job(20, 1, 0, 0);
`ifdef MM_TILE_SCHED_PERF_CNT_EN
    check("stall_cnt", int'(stall_cnt), 2 * 256);
`endif

    run_job(1, 2, 0, 0);

    run_job(20, 0, 0, 1);

    // Reset in the middle of draining tile 7.
    model_lat = 20; ready_mode = 0; gap_mode = 0;
    pulse_start();
    t = 0;
    while (xfers < 7 * TN * TN + 5 && t < 5000) begin
      @(negedge clk);
      #2;
      t++;
    end
    check("reached_tile7_drain", int'(xfers >= 7 * TN * TN + 5), 1);
    rst = 1'b1;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_blk_start", int'(bus.blk_start), 0);
    check("abort_block_row", int'(bus.block_row), 0);
    check("abort_block_col", int'(bus.block_col), 0);
    check("abort_out_we", int'(bus.out_we), 0);
    check("abort_out_addr", int'(bus.out_addr), 0);
    check("abort_out_data", int'(bus.out_data), 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run_job(20, 0, 0, 0);
    check("rerun_addr0_data", int'(data_at[8'h00]), 0);

    // blk_done lands on the final transfer of the previous tile.
    run_job(15, 0, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
